// File: rtl/tdm_ingress_mux.sv
// Six-port byte-stream ingress buffer, time-division multiplexed onto one slotted byte bus.
// Latency: registered output one edge after the slot decision; no bypass, so a pushed byte waits for its port's next slot edge.
// Backpressure: in_ready[p] is the registered not-full of port p's FIFO; TDM_SOP_CHECK_EN adds per-port start-of-packet policing and err_count.

// Generic single-clock FIFO with registered occupancy and a combinational head.
// Latency: a pushed entry is visible at the head one edge later.
// Backpressure: a push is refused whenever full at the edge, even if popped in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign head_dat = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end
endmodule

// TDM ingress mux: slot k of each 2^SLOT_WIDTH-cycle frame carries port k.
// Latency: output registered; slot ns = cnt+1 is decided and popped at the same edge it appears.
// Backpressure: per-port in_ready from FIFO not-full; discarded bytes (TDM_SOP_CHECK_EN) still handshake.
module tdm_ingress_mux #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_PORTS  = 6,
  parameter int SLOT_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            in_valid,
  input  logic [NUM_PORTS-1:0]            in_new_packet,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data,
  output logic [NUM_PORTS-1:0]            in_ready,
  output logic                            out_wire,
  output logic                            out_new_packet,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic [SLOT_WIDTH-1:0]           out_slot,
  output logic [15:0]                     err_count
);
  typedef struct packed {
    logic                  sop;
    logic [DATA_WIDTH-1:0] dat;
  } entry_t;

  logic [SLOT_WIDTH-1:0] cnt;
  logic [SLOT_WIDTH-1:0] ns;
  logic [NUM_PORTS-1:0]  full;
  logic [NUM_PORTS-1:0]  empty;
  logic [NUM_PORTS-1:0]  acc;
  logic [NUM_PORTS-1:0]  wr_en;
  logic [NUM_PORTS-1:0]  pop;
  entry_t                head [NUM_PORTS];
  entry_t                sel_dat;

  assign ns       = cnt + 1'b1;
  assign in_ready = ~full;
  assign acc      = in_valid & in_ready;
  // out_slot and the counter are the same register: the value on the bus is the slot it was chosen for.
  assign out_slot = cnt;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    sync_fifo #(
      .WIDTH ($bits(entry_t)),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (wr_en[p]),
      .push_dat ({in_new_packet[p], in_data[p*DATA_WIDTH +: DATA_WIDTH]}),
      .pop      (pop[p]),
      .head_dat (head[p]),
      .full     (full[p]),
      .empty    (empty[p])
    );
    // Only port ns can be popped, and only from occupancy seen at this edge (no bypass).
    assign pop[p] = (ns == SLOT_WIDTH'(p)) && !empty[p];
  end

  // Select the head of the (at most one) popped port; zero when the slot is idle.
  always_comb begin
    sel_dat = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (pop[i]) sel_dat = sel_dat | head[i];
    end
  end

  // Slot counter and registered bus outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt            <= '0;
      out_wire       <= 1'b0;
      out_new_packet <= 1'b0;
      out_data       <= '0;
    end else begin
      cnt            <= ns;
      out_wire       <= |pop;
      out_new_packet <= sel_dat.sop;
      out_data       <= sel_dat.dat;
    end
  end

`ifdef TDM_SOP_CHECK_EN
  typedef enum logic {S_IDLE, S_IN_PKT} sop_state_t;

  sop_state_t           st_q [NUM_PORTS];
  sop_state_t           st_d [NUM_PORTS];
  logic [NUM_PORTS-1:0] drop;
  logic [15:0]          err_q;
  logic [16:0]          err_sum;

  // Per-port packet-state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_PORTS; i++) st_q[i] <= S_IDLE;
    end else begin
      st_q <= st_d;
    end
  end

  // Until a port has seen a start-of-packet, its non-SOP bytes are accepted but dropped.
  always_comb begin
    drop  = '0;
    wr_en = acc;
    for (int i = 0; i < NUM_PORTS; i++) begin
      st_d[i] = st_q[i];
      case (st_q[i])
        S_IDLE: begin
          if (acc[i]) begin
            if (in_new_packet[i]) begin
              st_d[i] = S_IN_PKT;
            end else begin
              drop[i]  = 1'b1;
              wr_en[i] = 1'b0;
            end
          end
        end
        default: st_d[i] = S_IN_PKT;
      endcase
    end
  end

  // Add all of this cycle's drops at once, with one extra bit to detect saturation.
  always_comb begin
    err_sum = {1'b0, err_q};
    for (int i = 0; i < NUM_PORTS; i++) err_sum = err_sum + 17'(drop[i]);
  end

  // Saturating discard counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= '0;
    else     err_q <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end

  assign err_count = err_q;
`else
  assign wr_en     = acc;
  assign err_count = '0;
`endif
endmodule

// File: tb/tb_tdm_ingress_mux.sv
// Bench for tdm_ingress_mux: table of single-byte slot timings, hand sequences, random traffic.
// The reference model keeps one queue per port and serves port (cycle mod 256) each cycle.
// Honours TDM_SOP_CHECK_EN when defined for the build.
module tb_tdm_ingress_mux;
  localparam int DW = 8;
  localparam int NP = 6;
  localparam int SW = 8;
  localparam int FD = 16;

  logic             clk;
  logic             rst;
  logic [NP-1:0]    in_valid;
  logic [NP-1:0]    in_new_packet;
  logic [NP*DW-1:0] in_data;
  logic [NP-1:0]    in_ready;
  logic             out_wire;
  logic             out_new_packet;
  logic [DW-1:0]    out_data;
  logic [SW-1:0]    out_slot;
  logic [15:0]      err_count;

  tdm_ingress_mux #(
    .DATA_WIDTH (DW),
    .NUM_PORTS  (NP),
    .SLOT_WIDTH (SW),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_new_packet  (in_new_packet),
    .in_data        (in_data),
    .in_ready       (in_ready),
    .out_wire       (out_wire),
    .out_new_packet (out_new_packet),
    .out_data       (out_data),
    .out_slot       (out_slot),
    .err_count      (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc   = 0;
  logic [8:0]  mq [NP][$];
  bit          in_pkt [NP];
  int unsigned m_err;

  typedef struct {
    int         port;
    logic [7:0] data;
    int         drive_cyc;
    int         exp_cyc;
  } vec_t;
  vec_t tbl [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic drive(input int p, input bit v, input bit np, input logic [7:0] d);
    in_valid[p]          = v;
    in_new_packet[p]     = np;
    in_data[p*DW +: DW]  = d;
  endtask

  task automatic clear_inputs();
    in_valid      = '0;
    in_new_packet = '0;
    in_data       = '0;
  endtask

  // Assert reset off the clock edge, check outputs are cleared immediately, release after an edge.
  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    #2;
    chk("rst_out_wire", 32'(out_wire), 32'(0));
    chk("rst_out_np", 32'(out_new_packet), 32'(0));
    chk("rst_out_data", 32'(out_data), 32'(0));
    chk("rst_out_slot", 32'(out_slot), 32'(0));
    chk("rst_err_count", 32'(err_count), 32'(0));
    chk("rst_in_ready", 32'(in_ready), 32'(6'h3F));
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int p = 0; p < NP; p++) begin
      mq[p].delete();
      in_pkt[p] = 1'b0;
    end
    m_err = 0;
    cyc   = 0;
  endtask

  // One clock: check readiness, advance, update the queue model, compare the bus.
  task automatic step();
    logic [NP-1:0] rdy_exp;
    logic [NP-1:0] acc;
    logic [8:0]    entry;
    logic          e_wire;
    logic          e_np;
    logic [7:0]    e_data;
    int            ns;
    for (int p = 0; p < NP; p++) rdy_exp[p] = (mq[p].size() < FD);
    chk("in_ready", 32'(in_ready), 32'(rdy_exp));
    acc = in_valid & rdy_exp;
    @(posedge clk);
    #1;
    cyc++;
    ns     = cyc % 256;
    e_wire = 1'b0;
    e_np   = 1'b0;
    e_data = 8'h00;
    if (ns < NP && mq[ns].size() > 0) begin
      entry  = mq[ns].pop_front();
      e_wire = 1'b1;
      e_np   = entry[8];
      e_data = entry[7:0];
    end
    for (int p = 0; p < NP; p++) begin
      if (acc[p]) begin
`ifdef TDM_SOP_CHECK_EN
        if (!in_pkt[p] && !in_new_packet[p]) begin
          if (m_err < 65535) m_err++;
        end else begin
          if (in_new_packet[p]) in_pkt[p] = 1'b1;
          mq[p].push_back({in_new_packet[p], in_data[p*DW +: DW]});
        end
`else
        mq[p].push_back({in_new_packet[p], in_data[p*DW +: DW]});
`endif
      end
    end
    chk("out_wire", 32'(out_wire), 32'(e_wire));
    chk("out_new_packet", 32'(out_new_packet), 32'(e_np));
    chk("out_data", 32'(out_data), 32'(e_data));
    chk("out_slot", 32'(out_slot), 32'(ns));
    chk("err_count", 32'(err_count), 32'(m_err));
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  initial begin
    int  n;
    bit  will;
    rst = 1'b1;
    clear_inputs();

    // {port, byte, cycle driven, cycle it must appear on the bus}
    tbl[0] = '{0, 8'h3C, 0,   256};  // port 0 first served a full frame later
    tbl[1] = '{2, 8'h5A, 256, 258};  // pushed before its slot edge
    tbl[2] = '{2, 8'hA5, 257, 514};  // pushed on its slot edge: no bypass
    tbl[3] = '{5, 8'h77, 3,   5};
    tbl[4] = '{5, 8'h88, 4,   261};  // lands on the slot edge itself

    // Idle run: bus stays quiet, slot follows the cycle count through a wrap.
    do_reset();
    run_to(600);

    // Table of single-byte slot timings.
    for (int i = 0; i < 5; i++) begin
      do_reset();
      run_to(tbl[i].drive_cyc);
      drive(tbl[i].port, 1'b1, 1'b1, tbl[i].data);
      step();
      clear_inputs();
      run_to(tbl[i].exp_cyc);
      chk("tbl_wire", 32'(out_wire), 32'(1));
      chk("tbl_slot", 32'(out_slot), 32'(tbl[i].port));
      chk("tbl_data", 32'(out_data), 32'(tbl[i].data));
      chk("tbl_np", 32'(out_new_packet), 32'(1));
    end

    // Port 2 three-byte packet: one byte per frame.
    do_reset();
    run_to(10);
    drive(2, 1'b1, 1'b1, 8'hA1); step();
    drive(2, 1'b1, 1'b0, 8'hA2); step();
    drive(2, 1'b1, 1'b0, 8'hA3); step();
    clear_inputs();
    run_to(258);
    chk("p2_b0_data", 32'(out_data), 32'hA1);
    chk("p2_b0_np", 32'(out_new_packet), 32'(1));
    run_to(514);
    chk("p2_b1_data", 32'(out_data), 32'hA2);
    run_to(770);
    chk("p2_b2_data", 32'(out_data), 32'hA3);
    chk("p2_b2_wire", 32'(out_wire), 32'(1));
    run_to(771);

    // All ports at once.
    do_reset();
    run_to(5);
    for (int p = 0; p < NP; p++) drive(p, 1'b1, 1'b1, 8'(8'h10 + p));
    step();
    clear_inputs();
    for (int s = 0; s < NP; s++) begin
      run_to(256 + s);
      chk("all_wire", 32'(out_wire), 32'(1));
      chk("all_data", 32'(out_data), 32'(8'h10 + s));
      chk("all_np", 32'(out_new_packet), 32'(1));
    end

    // Port 4 fills, stalls, and resumes once its slot drains one entry.
    do_reset();
    run_to(5);
    n = 0;
    while (cyc < 262) begin
      drive(4, 1'b1, (n == 0), 8'(8'h40 + n));
      will = (mq[4].size() < FD);
      step();
      if (will) n++;
      if (cyc == 20)  chk("p4_ready_15", 32'(in_ready[4]), 32'(1));
      if (cyc == 21)  chk("p4_ready_full", 32'(in_ready[4]), 32'(0));
      if (cyc == 259) chk("p4_ready_held", 32'(in_ready[4]), 32'(0));
      if (cyc == 260) begin
        chk("p4_ready_back", 32'(in_ready[4]), 32'(1));
        chk("p4_pop_data", 32'(out_data), 32'h40);
      end
    end
    clear_inputs();
    run_to(263);

    // Reset while port 1 is mid-transmission; nothing old may reappear.
    do_reset();
    run_to(1);
    for (int i = 0; i < 5; i++) begin
      drive(1, 1'b1, (i == 0), 8'(8'h90 + i));
      step();
    end
    clear_inputs();
    run_to(257);
    chk("p1_before_rst", 32'(out_wire), 32'(1));
    do_reset();
    run_to(600);

    // Start-of-packet policing on port 3.
    do_reset();
    run_to(10);
    drive(3, 1'b1, 1'b0, 8'h55); step();
    drive(3, 1'b1, 1'b1, 8'h66); step();
    clear_inputs();
    run_to(259);
`ifdef TDM_SOP_CHECK_EN
    chk("sop_err", 32'(err_count), 32'(1));
    chk("sop_data", 32'(out_data), 32'h66);
    chk("sop_np", 32'(out_new_packet), 32'(1));
    run_to(515);
    chk("sop_idle", 32'(out_wire), 32'(0));
`else
    chk("nosop_err", 32'(err_count), 32'(0));
    chk("nosop_data0", 32'(out_data), 32'h55);
    run_to(515);
    chk("nosop_data1", 32'(out_data), 32'h66);
    chk("nosop_np1", 32'(out_new_packet), 32'(1));
`endif

    // Random traffic against the queue model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < NP; p++) begin
        drive(p, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 8'($urandom_range(0, 255)));
      end
      step();
    end
    clear_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/tdm_ingress_mux.md
Name: tdm_ingress_mux

Overview:
- Upstream neighbour of the 6x6 BPU top.
- Accepts six independent byte-stream ports, buffers each in its own FIFO, and time-division multiplexes them onto the single slotted byte bus (wire / new_packet / data) that the BPU demultiplexes with its free-running 8-bit slot counter.
- Slot k of every 256-cycle frame carries port k (k < NUM_PORTS). Slots NUM_PORTS..255 are always idle.

Parameters:
- DATA_WIDTH, 8, byte width of every port and of the TDM bus.
- NUM_PORTS, 6, number of ingress ports / active slots. Must be ≤ 2^SLOT_WIDTH.
- SLOT_WIDTH, 8, width of the slot counter. Frame length is 2^SLOT_WIDTH cycles.
- FIFO_DEPTH, 16, entries per port FIFO. Power of two, ≥ 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  NUM_PORTS  per-port byte valid.
- in_new_packet  in  NUM_PORTS  per-port first-byte-of-packet flag. Qualified by in_valid.
- in_data  in  NUM_PORTS*DATA_WIDTH  per-port byte. Port p occupies bits [p*DATA_WIDTH +: DATA_WIDTH].
- in_ready  out  NUM_PORTS  per-port FIFO not full.
- out_wire  out  1  TDM byte valid; drives the BPU input_wire.
- out_new_packet  out  1  TDM start-of-packet flag.
- out_data  out  DATA_WIDTH  TDM byte.
- out_slot  out  SLOT_WIDTH  slot index that the current out_* values belong to.
- err_count  out  16  count of discarded bytes (optional feature only).

Behaviour:
- Reset:
  - All FIFOs empty; slot counter cnt = 0.
  - out_wire = 0, out_new_packet = 0, out_data = 0, out_slot = 0.
  - in_ready = all ones; err_count = 0.
  - Reset mid-operation discards all buffered bytes immediately; no partial packet survives.
- Push:
  - A byte is written to FIFO p when in_valid[p] && in_ready[p]. Stored entry = {new_packet, data}.
  - in_ready[p] = !full[p], derived from registered occupancy only.
  - A FIFO that is full at the clock edge refuses the push even if it is popped in the same cycle.
  - in_valid without in_ready is not a transfer; the source holds the byte.
- Slot counter:
  - cnt increments every cycle and wraps 2^SLOT_WIDTH-1 -> 0.
  - It is the same counter value the BPU holds, since both are reset together and advance in lockstep.
- Output (registered, one-cycle latency from slot decision):
  - At each edge, ns = cnt+1 (mod 2^SLOT_WIDTH) and out_slot <= ns.
  - If ns < NUM_PORTS and FIFO[ns] is non-empty: pop head; out_wire <= 1; out_new_packet <= stored flag; out_data <= stored byte.
  - Otherwise: out_wire <= 0, out_new_packet <= 0, out_data <= 0.
  - Result: during a cycle where the BPU slot equals k, the bus carries port k's byte, and out_slot == BPU slot in every cycle.
- Boundary cases:
  - Port 0 cannot be served in the first cycle after reset; its first service is at cycle 2^SLOT_WIDTH.
- Ordering and throughput:
  - Bytes leave each port in arrival order.
  - Bytes of one packet may be separated by idle frames when the FIFO runs dry; downstream tolerates this.
  - Maximum throughput is one byte per port per frame.
- Simultaneous push and pop on the same FIFO in one cycle: both occur, and occupancy is unchanged.
- No bypass: a push into an empty FIFO is first eligible at that port's next slot edge after the push edge.
- Occupancy counters are log2(FIFO_DEPTH)+1 bits wide. Read and write pointers wrap modulo FIFO_DEPTH.

Optional Feature:
- Macro: TDM_SOP_CHECK_EN.
- Defined:
  - Each port has a 2-state FSM: IDLE / IN_PKT, reset to IDLE.
  - In IDLE, an accepted byte with new_packet=0 is discarded (not written) and err_count increments, saturating at 16'hFFFF.
  - A byte with new_packet=1 is written and moves the FSM to IN_PKT.
  - IN_PKT stays until reset; a new SOP is written normally.
  - in_ready behaviour is unchanged, so discarded bytes still complete their handshake.
  - Simultaneous discards on several ports in one cycle add their total count to err_count.
- Undefined: every accepted byte is written and err_count is tied to 0.

Test Plan:
- Reset release, no input, run 600 cycles -> out_wire=0 throughout; out_slot follows 0,1,...,255,0 in step with the cycle count.
- Port 2 pushes 3 bytes (SOP 0xA1, then 0xA2, 0xA3) at cycles 10-12 -> out_wire=1 with out_slot=2 at cycles 258, 514, 770, carrying 0xA1 (out_new_packet=1), 0xA2, 0xA3; all other slots idle.
- All six ports push byte 0x10+p at cycle 5 -> in the frame starting at cycle 256, slots 0..5 carry 0x10..0x15, each with out_new_packet=1.
- Port 4 holds in_valid=1 for 20 cycles, no service yet -> in_ready[4] drops after 16 accepts. At cycle 260 the FIFO pops; with in_valid still high, in_ready returns to 1 and a push is accepted at the next edge.
- Reset asserted mid-frame with port 1 holding 5 bytes -> outputs go 0 asynchronously; after release, no old byte ever appears on slot 1.
- TDM_SOP_CHECK_EN: port 3 sends 0x55 (no SOP), then 0x66 with SOP -> err_count=1; only 0x66 appears on slot 3, with out_new_packet=1.
